fake_cone_share_arbiter: RTL and testbench

Round-robin scheduler that time-shares one combinational logic cone (5 inputs, 1 output, ASAP7 gate-level) among several requesters. Each requester offers an input vector over a valid/ready handshake. The block drives the granted vector onto the cone, waits a programmable settle time, captures the cone output, and returns it tagged with the requester index. It sits between the requester fabric and the cone instance; the cone is external and purely combinational.

---
 rtl/fake_cone_share_arbiter.sv | 108 ++++++++++
 tb/tb_fake_cone_share_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fake_cone_share_arbiter.sv
// Round-robin time-share of one external combinational cone among NREQ requesters.
// Grants a vector, holds it on cone_in for SETTLE+1 cycles, then returns the captured result.
module fake_cone_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int IN_W   = 5,
  parameter int SETTLE = 1,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IN_W-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [IN_W-1:0]      cone_in,
  input  logic                 cone_out,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_data,
  input  logic                 rsp_ready,
  output logic                 busy,
  output logic [15:0]          eval_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant;
  logic            any_valid;
  logic [3:0]      cnt;

  // Search from ptr upward; iterating downward lets the nearest valid requester win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant     = ptr;
    any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        grant     = ID_W'((int'(ptr) + k) % NREQ);
        any_valid = 1'b1;
      end
    end
  end

  // req_ready is suppressed while rst is asserted even though state already reads IDLE.
  assign req_ready = (state == S_IDLE && any_valid && !rst) ? (NREQ'(1) << grant) : '0;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_valid)   state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:   if (rsp_ready)   state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      cnt        <= '0;
      cone_in    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= 1'b0;
      eval_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            cone_in <= req_data[int'(grant)*IN_W +: IN_W];
            rsp_id  <= grant;
            ptr     <= (int'(grant) == NREQ - 1) ? '0 : grant + ID_W'(1);
            cnt     <= 4'(SETTLE);
          end
        end
        S_SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_data  <= cone_out;
            rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          // Response stays frozen until taken; cone_in is intentionally never cleared.
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            eval_count <= eval_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fake_cone_share_arbiter.sv
// Self-checking bench: directed scenarios then random traffic against a timestamp-based
// transaction model; a second SETTLE=0 instance covers zero-settle timing and counter wrap.
module tb_fake_cone_share_arbiter;

  localparam int NREQ   = 4;
  localparam int IN_W   = 5;
  localparam int SETTLE = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IN_W-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic [IN_W-1:0]      cone_in;
  logic                 cone_out;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic                 rsp_data;
  logic                 rsp_ready;
  logic                 busy;
  logic [15:0]          eval_count;

  logic [NREQ-1:0]      v_z;
  logic [NREQ*IN_W-1:0] d_z;
  logic [NREQ-1:0]      ready_z;
  logic [IN_W-1:0]      cone_in_z;
  logic                 co_z;
  logic                 rsp_valid_z;
  logic [1:0]           rsp_id_z;
  logic                 rsp_data_z;
  logic                 rr_z;
  logic                 busy_z;
  logic [15:0]          count_z;

  always #5 clk = ~clk;

  fake_cone_share_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cone_in(cone_in), .cone_out(cone_out), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy), .eval_count(eval_count)
  );

  fake_cone_share_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .SETTLE(0)) dut_s0 (
    .clk(clk), .rst(rst), .req_valid(v_z), .req_data(d_z), .req_ready(ready_z),
    .cone_in(cone_in_z), .cone_out(co_z), .rsp_valid(rsp_valid_z), .rsp_id(rsp_id_z),
    .rsp_data(rsp_data_z), .rsp_ready(rr_z), .busy(busy_z), .eval_count(count_z)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model of the main instance.
  bit     m_pending;
  bit     m_rsp;
  int     m_ptr;
  int     m_t_acc;
  int     m_id;
  int     m_data;
  int     m_cone;
  int     m_count;
  int     cyc;
  int     grants[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_pending = 0; m_rsp = 0; m_ptr = 0; m_t_acc = 0;
    m_id = 0; m_data = 0; m_cone = 0; m_count = 0;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".busy"},       busy,       m_pending);
    check({tag, ".rsp_valid"},  rsp_valid,  m_rsp);
    check({tag, ".rsp_id"},     rsp_id,     m_id);
    check({tag, ".rsp_data"},   rsp_data,   m_data);
    check({tag, ".cone_in"},    cone_in,    m_cone);
    check({tag, ".eval_count"}, eval_count, m_count);
  endtask

  // One clock cycle: entered and left at a falling edge with inputs already driven.
  task automatic step(input string tag);
    int g;
    #1;
    g = m_pending ? -1 : first_grant(req_valid, m_ptr);
    check({tag, ".req_ready"}, req_ready, (g < 0) ? 0 : (1 << g));
    @(posedge clk);
    if (!m_pending) begin
      if (g >= 0) begin
        m_cone    = int'(req_data[g*IN_W +: IN_W]);
        m_id      = g;
        m_ptr     = (g + 1) % NREQ;
        m_t_acc   = cyc;
        m_pending = 1;
        grants.push_back(g);
      end
    end else if (!m_rsp) begin
      if (cyc == m_t_acc + SETTLE + 1) begin
        m_data = int'(cone_out);
        m_rsp  = 1;
      end
    end else if (rsp_ready) begin
      m_rsp     = 0;
      m_pending = 0;
      m_count   = (m_count + 1) % 65536;
    end
    cyc++;
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; cone_out = 1'b0; rsp_ready = 1'b0;
    v_z = '0; d_z = '0; co_z = 1'b0; rr_z = 1'b0;
    cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("por");
    check("por.req_ready", req_ready, 0);
    rst = 1'b0;

    // Zero-settle instance: capture on the edge right after accept, then counter wrap.
    v_z = 4'b0010; d_z[9:5] = 5'h0A; co_z = 1'b1;
    #1 check("s0.req_ready", ready_z, 4'b0010);
    @(posedge clk); @(negedge clk);
    check("s0.accept.busy", busy_z, 1);
    check("s0.accept.cone_in", cone_in_z, 5'h0A);
    check("s0.accept.rsp_valid", rsp_valid_z, 0);
    v_z = '0;
    @(posedge clk); @(negedge clk);
    check("s0.capture.rsp_valid", rsp_valid_z, 1);
    check("s0.capture.rsp_id", rsp_id_z, 1);
    check("s0.capture.rsp_data", rsp_data_z, 1);
    co_z = 1'b0;
    force dut_s0.eval_count = 16'hFFFF;
    #1 release dut_s0.eval_count;
    #1 check("s0.preload", count_z, 16'hFFFF);
    rr_z = 1'b1;
    @(posedge clk); @(negedge clk);
    check("s0.wrap.eval_count", count_z, 0);
    check("s0.wrap.rsp_valid", rsp_valid_z, 0);
    check("s0.wrap.busy", busy_z, 0);
    rr_z = 1'b0;

    // Single request on requester 0.
    req_valid = 4'b0001; req_data[4:0] = 5'b10110; cone_out = 1'b1; rsp_ready = 1'b1;
    step("single");
    check("single.cone_in", cone_in, 5'b10110);
    req_valid = '0;
    repeat (4) step("single");
    check("single.eval_count", eval_count, 1);
    check("single.rsp_data", rsp_data, 1);

    // Reset asserted mid-SETTLE with every requester still valid.
    req_valid = 4'b1000; req_data = 20'hABCDE; rsp_ready = 1'b1;
    step("pre_rst");
    req_valid = 4'b1111;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst.req_ready", req_ready, 0);
    check_outputs("rst");
    @(posedge clk); @(negedge clk);
    check("rst_hold.req_ready", req_ready, 0);
    check_outputs("rst_hold");
    rst = 1'b0; req_valid = '0;
    repeat (4) step("post_rst");

    // Round-robin fairness with all requesters continuously valid.
    grants.delete();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      req_data = 20'($urandom); cone_out = 1'($urandom);
      step("rr");
    end
    check("rr.count", grants.size(), 8);
    for (int i = 0; i < 8 && i < grants.size(); i++) check($sformatf("rr.grant%0d", i), grants[i], i % 4);
    req_valid = '0;
    repeat (4) step("rr_drain");

    // Skip and wrap: drive ptr to 3, then only requesters 0 and 2 valid.
    req_valid = 4'b0100;
    step("skip_pre");
    req_valid = '0;
    repeat (3) step("skip_pre");
    grants.delete();
    req_valid = 4'b0101;
    repeat (8) step("skip");
    req_valid = 4'b1111;
    step("skip");
    check("skip.count", grants.size(), 3);
    if (grants.size() == 3) begin
      check("skip.grant0", grants[0], 0);
      check("skip.grant1", grants[1], 2);
      check("skip.grant2", grants[2], 3);
    end
    req_valid = '0;
    repeat (4) step("skip_drain");

    // Backpressure: response held for 5 cycles while cone_out toggles.
    grants.delete();
    rsp_ready = 1'b0; req_valid = 4'b0010; cone_out = 1'b1;
    step("bp");
    req_valid = 4'b1111;
    repeat (2) step("bp");
    check("bp.rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cone_out = ~cone_out;
      step("bp_hold");
    end
    check("bp.accepts", grants.size(), 1);
    check("bp.rsp_data", rsp_data, 1);
    rsp_ready = 1'b1; req_valid = '0;
    step("bp_release");
    check("bp.released", rsp_valid, 0);
    repeat (3) step("bp_drain");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom);
      req_data  = 20'($urandom);
      cone_out  = 1'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
